// File: rtl/icache_direct_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : icache_direct_pkg                                  |
// | Description : Shared constants and FSM state encoding for the    |
// |               direct-mapped instruction cache.                   |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package icache_direct_pkg;

  localparam logic        TRUE  = 1'b1;
  localparam logic        FALSE = 1'b0;
  localparam logic [31:0] ZERO  = 32'h0000_0000;

  // Cache controller states
  typedef enum logic [1:0] {
    ICACHE_IDLE  = 2'd0,
    ICACHE_MISS  = 2'd1,
    ICACHE_DRAIN = 2'd2
  } icache_state_e;

  // Word-align a byte address for the memory controller fetch port
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_direct_array.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : icache_direct_array                                |
// | Description : Valid bits (async reset), tag RAM and data RAM     |
// |               with one combinational read and one write port.    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module icache_direct_array #(
  parameter int INDEX_BITS = 8,
  parameter int TAG_BITS   = 32 - 2 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    valid_d;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  // Next valid vector: a fill marks its line valid
  always_comb begin
    valid_d = valid_q;
    if (we) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  // Valid bits are the only array state that must clear on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data storage, written on a fill
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/icache_direct.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : icache_direct                                      |
// | Description : Direct-mapped one-word-per-line instruction cache  |
// |               with miss refill and flush-drain handling.         |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int INDEX_BITS = 8,
  parameter int TAG_BITS   = 32 - 2 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic        fet_ena,
  output logic [31:0] instr_addr,
  input  logic        valid_2icache,
  input  logic [31:0] data_2icache
);

  icache_state_e         state_q,      state_d;
  logic                  if_valid_q,   if_valid_d;
  logic [31:0]           if_instr_q,   if_instr_d;
  logic                  fet_ena_q,    fet_ena_d;
  logic [31:0]           instr_addr_q, instr_addr_d;
  logic [INDEX_BITS-1:0] req_idx_q,    req_idx_d;
  logic [TAG_BITS-1:0]   req_tag_q,    req_tag_d;

  logic [INDEX_BITS-1:0] pc_idx;
  logic [TAG_BITS-1:0]   pc_tag;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [31:0]           rd_data;
  logic                  hit;
  logic                  fill_we;
  logic                  unused_pc_bits;

  assign pc_idx         = if_pc[INDEX_BITS+1:2];
  assign pc_tag         = if_pc[31:INDEX_BITS+2];
  assign unused_pc_bits = ^if_pc[1:0];
  assign hit            = rd_valid && (rd_tag == pc_tag);

  icache_direct_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pc_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (fill_we),
    .wr_idx   (req_idx_q),
    .wr_tag   (req_tag_q),
    .wr_data  (data_2icache)
  );

  // Next-state and output logic; rdy low freezes everything including if_valid
  always_comb begin
    state_d      = state_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    fet_ena_d    = fet_ena_q;
    instr_addr_d = instr_addr_q;
    req_idx_d    = req_idx_q;
    req_tag_d    = req_tag_q;
    fill_we      = FALSE;
    if (rdy) begin
      if_valid_d = FALSE;
      case (state_q)
        ICACHE_IDLE: begin
          if (if_req && !clear) begin
            if (hit) begin
              if_valid_d = TRUE;
              if_instr_d = rd_data;
            end else begin
              state_d      = ICACHE_MISS;
              fet_ena_d    = TRUE;
              instr_addr_d = word_align(if_pc);
              req_idx_d    = pc_idx;
              req_tag_d    = pc_tag;
            end
          end
        end
        ICACHE_MISS: begin
          if (valid_2icache) begin
            // A flush in the fill cycle still fills the line but suppresses the response
            fill_we   = TRUE;
            fet_ena_d = FALSE;
            state_d   = ICACHE_IDLE;
            if (!clear) begin
              if_valid_d = TRUE;
              if_instr_d = data_2icache;
            end
          end else if (clear) begin
            state_d = ICACHE_DRAIN;
          end
        end
        ICACHE_DRAIN: begin
          // The memory transaction runs to completion; its word still fills the line
          if (valid_2icache) begin
            fill_we   = TRUE;
            fet_ena_d = FALSE;
            state_d   = ICACHE_IDLE;
          end
        end
        default: begin
          state_d   = ICACHE_IDLE;
          fet_ena_d = FALSE;
        end
      endcase
    end
  end

  // Controller and handshake registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ICACHE_IDLE;
      if_valid_q   <= FALSE;
      if_instr_q   <= ZERO;
      fet_ena_q    <= FALSE;
      instr_addr_q <= ZERO;
      req_idx_q    <= '0;
      req_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      fet_ena_q    <= fet_ena_d;
      instr_addr_q <= instr_addr_d;
      req_idx_q    <= req_idx_d;
      req_tag_q    <= req_tag_d;
    end
  end

  assign if_valid   = if_valid_q;
  assign if_instr   = if_instr_q;
  assign fet_ena    = fet_ena_q;
  assign instr_addr = instr_addr_q;

endmodule
`default_nettype wire

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, one-word-per-line instruction cache between the instruction-fetch unit and the memory controller. It serves fetch requests from its tag/data array on a hit. On a miss it drives the memory controller's fetch port (`fet_ena`/`instr_addr`), waits for the assembled 32-bit word, fills the line, and returns the instruction. It also supports a pipeline flush that discards an in-flight response without aborting the memory transaction.

## Interface
Parameters:
- `INDEX_BITS`, 8: line-index width; 2^INDEX_BITS lines of one 32-bit word each.
- `TAG_BITS`, 32-2-INDEX_BITS: derived; tag width.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset; asynchronous, active-low (rst==0 resets immediately).
- `rdy` input 1: global enable; 0 freezes all state and outputs.
- `clear` input 1: pipeline flush from the commit stage.
- `if_req` input 1: fetch request from the IF unit.
- `if_pc` input 32: fetch address; bits [1:0] are ignored.
- `if_valid` output 1: one-cycle pulse; `if_instr` is valid.
- `if_instr` output 32: instruction word.
- `fet_ena` output 1: fetch request to the memory controller.
- `instr_addr` output 32: word-aligned fetch address, `{if_pc[31:2],2'b00}`.
- `valid_2icache` input 1: one-cycle pulse from the memory controller; fill word ready.
- `data_2icache` input 32: fill word, little-endian assembled.

## Operation
- Address split:
  - index = `pc[INDEX_BITS+1:2]`.
  - tag = `pc[31:INDEX_BITS+2]`.
- States: IDLE, MISS, DRAIN.
- IDLE:
  - Accept a request when `if_req` is 1 and `clear` is 0.
  - Hit (line valid and tag equal): set `if_valid` to 1 and `if_instr` to the line data; stay in IDLE.
  - Miss: go to MISS; set `fet_ena` to 1; latch `instr_addr` and the request tag/index.
- MISS:
  - Hold `fet_ena` and `instr_addr` stable until `valid_2icache` is sampled 1.
  - On `valid_2icache` being sampled 1:
    - Write data, tag and valid bit to the latched index.
    - Set `if_valid` to 1 and `if_instr` to `data_2icache`.
    - Set `fet_ena` to 0; go to IDLE.
  - `clear`=1 while in MISS with no fill that cycle: go to DRAIN; `fet_ena` stays 1.
- DRAIN:
  - On `valid_2icache`: write the line; `if_valid` stays 0; set `fet_ena` to 0; go to IDLE.
  - The memory controller transaction is never aborted.
- `clear` in IDLE: no request is accepted that cycle; `if_valid` is forced to 0.
- `clear` in the same cycle as `valid_2icache` in MISS: the line is filled and `if_valid` stays 0.
- `if_valid` defaults to 0 every cycle unless set by the rules above.
- The IF unit holds `if_req`/`if_pc` stable until `if_valid`, or until it asserts `clear`.
- Reset (`rst`=0, at any time including mid-miss):
  - State goes to IDLE.
  - All valid bits are cleared.
  - `if_valid`, `fet_ena`, `instr_addr` and `if_instr` go to 0.
  - The data/tag arrays are not required to reset.
- `rdy`=0: no state change, no array write; all outputs hold.

## Timing
- Hit latency: request sampled at edge T; `if_valid` is high during cycle T+1.
- Miss:
  - `fet_ena` rises at edge T.
  - The memory controller takes it in its idle state and pulses `valid_2icache` after fetching 4 bytes (about 6 cycles).
  - `if_valid` is high in the cycle after the edge that samples `valid_2icache`.
- `fet_ena` drops at the same edge that samples `valid_2icache`. The memory controller spends 2 cycles in its post-fill stall states, so it never sees a stale `fet_ena`.
- Back-to-back misses: `fet_ena` may rise again the cycle after IDLE is re-entered. The memory controller samples it once it returns to its idle state; no extra handshake is needed.
- A fill at index i and a new request hitting index i are never in the same cycle, because requests are accepted only in IDLE.

## Structure
- Shared constants (`TRUE`, `FALSE`, `ZERO`, `ADDR_IDX`, `DATA_IDX_RANGE`) come from `const.v`.
- Add the state encodings `ICACHE_IDLE`, `ICACHE_MISS`, `ICACHE_DRAIN` to `const.v`.
- Sub-module `icache_array` holds valid bits (async-reset), tag RAM and data RAM. It has one read port (combinational) and one write port.
- The top level holds the FSM and the handshake registers. Total RTL is roughly 150–250 lines.

## Test plan
- Reset, then request pc=0x0000_0000 → `fet_ena`=1 with `instr_addr`=0x0; model returns 0x0000_0513 → `if_valid` pulse with `if_instr`=0x0000_0513.
- Request the same pc again → `if_valid` the next cycle with 0x0000_0513; `fet_ena` stays 0.
- Requests at 0x0000_0400 and 0x0000_0000 (same index 0, different tag, INDEX_BITS=8) → each misses and refetches alternately.
- `clear` during MISS for pc=0x10 → no `if_valid`; the line is still filled. A later request to 0x10 hits in 1 cycle.
- Hold `rdy`=0 for 5 cycles mid-miss → `fet_ena`/`instr_addr` hold and nothing is lost; completion follows after `rdy` returns to 1.
- Assert `rst`=0 mid-miss, then release → `fet_ena`=0 immediately and all lines are invalid; a request to 0x0 misses again.
